uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQUESTERS, default 4, number of requester ports (2..8).
REQ-002 SHALL have parameter INPUT_DATA_WIDTH, default 8, width of one UART data word.
REQ-003 SHALL have parameter BUSY_TIMEOUT, default 256, the maximum number of cycles to wait for uart_busy to rise.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-low reset (reset==0 resets the block).
REQ-006 SHALL have port req, input, NUM_REQUESTERS bits: request from each requester, held until that requester's grant.
REQ-007 SHALL have port req_data, input, NUM_REQUESTERS*INPUT_DATA_WIDTH bits: word for requester i in slice [i*W +: W].
REQ-008 SHALL have port grant, output, NUM_REQUESTERS bits: one-hot, one-cycle pulse when a word is accepted.
REQ-009 SHALL have port done, output, NUM_REQUESTERS bits: one-hot, one-cycle pulse when that word has finished transmitting.
REQ-010 SHALL have port uart_enable, output, 1 bit: drives the UART transmitter enable.
REQ-011 SHALL have port uart_data, output, INPUT_DATA_WIDTH bits: drives the UART transmitter i_data.
REQ-012 SHALL have port uart_busy, input, 1 bit: the UART transmitter o_busy.
REQ-013 SHALL have port active_id, output, $clog2(NUM_REQUESTERS) bits: index of the current owner.

Function
REQ-014 SHALL implement the FSM states IDLE, ISSUE, WAIT_DONE, plus ERROR_RECOVER when UART_ARB_TIMEOUT_EN is defined.
REQ-015 IDLE: if any req bit is set and uart_busy==0, SHALL select the first set bit at or after rr_ptr (wrapping), latch its data into uart_data, pulse its grant, set active_id, and go to ISSUE the next cycle.
REQ-016 IDLE with req==0, or with uart_busy==1, SHALL stay in IDLE with no grant issued.
REQ-017 ISSUE: SHALL hold uart_enable=1 until uart_busy==1 is sampled, then deassert uart_enable in the same cycle and go to WAIT_DONE.
REQ-018 WAIT_DONE: on uart_busy==0, SHALL pulse done[active_id], set rr_ptr=active_id+1 (mod NUM_REQUESTERS), and return to IDLE.
REQ-019 uart_data SHALL remain stable from the grant until the cycle after done; it SHALL change only in IDLE on a new grant.
REQ-020 uart_enable SHALL never be 1 while the FSM is in WAIT_DONE, and SHALL never be 1 in a cycle where uart_busy==1 is sampled.
REQ-021 Grant latency from the req rise (FSM in IDLE, UART idle) SHALL be 1 cycle; no new grant SHALL be issued earlier than the cycle after done.
REQ-022 A requester deasserting req before its grant SHALL be skipped without error; req changes after grant SHALL be ignored.
REQ-023 At most one grant bit and one done bit SHALL be set per cycle.
REQ-024 In the round-robin order, a requester that is continuously requesting SHALL be granted within NUM_REQUESTERS transactions.

Reset
REQ-025 On reset==0 at a clock edge, the block SHALL set: FSM=IDLE, rr_ptr=0, active_id=0, grant=0, done=0, uart_enable=0, uart_data=0, timeout counter=0, arb_error=0.
REQ-026 A reset during ISSUE or WAIT_DONE SHALL abandon the transaction with no done pulse, and uart_enable SHALL be 0 in the cycle after reset.

Configuration
REQ-027 When UART_ARB_TIMEOUT_EN is defined, the block SHALL count cycles in ISSUE; if uart_busy has not risen after BUSY_TIMEOUT cycles, it SHALL drop uart_enable, pulse output arb_error (1 bit) for one cycle, advance rr_ptr, and go through ERROR_RECOVER to IDLE without a done pulse.
REQ-028 When UART_ARB_TIMEOUT_EN is undefined, the arb_error port and the counter SHALL be absent, and ISSUE SHALL wait indefinitely.

Structure
REQ-029 The FSM state encodings and the reset/timeout default constants SHALL live in the shared package uart_pkg.
REQ-030 The round-robin selection SHALL be one sub-module, rr_priority_select (inputs req and ptr; outputs one-hot and index), which is purely combinational.

Verification
REQ-031 After reset, req=4'b0001 with data 8'hA5 -> grant[0] 1 cycle later; uart_enable high until busy; loopback receives 8'hA5; done[0] pulses; rx_error never set.
REQ-032 req=4'b1111 held, rr_ptr=0 -> grant order 0,1,2,3,0 with data 8'h11,8'h22,8'h33,8'h44 received in that order.
REQ-033 Requester 2 continuously requesting, requester 1 arriving at rr_ptr=2 -> grants alternate 2,1,2.
REQ-034 reset driven low mid-WAIT_DONE of requester 1 -> uart_enable=0 and no done[1]; after release, req=4'b0010 is granted first.
REQ-035 With UART_ARB_TIMEOUT_EN defined, BUSY_TIMEOUT=16 and uart_busy forced to 0 -> arb_error pulses at cycle 16 of ISSUE, no done pulse, and the next requester is granted.
REQ-036 Formal: uart_enable is never high while uart_busy is high; uart_data is stable between grant and done; grant and done are each at most one-hot.

Source files
------------

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg -- shared definitions for the UART transmit arbiter.
//
// Contents:
//   DEFAULT_*     default parameter values used by the arbiter and its interface
//   arb_state_e   arbiter FSM state encoding
//   RESET_STATE   state entered on reset
//   RESET_COUNT   timeout counter value entered on reset
//   wrap_add()    modular addition used for round-robin pointer arithmetic
//
// Optional feature macro: UART_ARB_TIMEOUT_EN adds the ERROR_RECOVER state.
// -----------------------------------------------------------------------------
package uart_pkg;

  localparam int unsigned DEFAULT_NUM_REQUESTERS = 4;
  localparam int unsigned DEFAULT_DATA_WIDTH     = 8;
  localparam int unsigned DEFAULT_BUSY_TIMEOUT   = 256;
  localparam int unsigned RESET_COUNT            = 0;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_DONE = 2'd2
`ifdef UART_ARB_TIMEOUT_EN
    ,
    ERROR_RECOVER = 2'd3
`endif
  } arb_state_e;

  localparam arb_state_e RESET_STATE = IDLE;

  // (a + b) mod n, used to walk requesters starting at the round-robin pointer.
  function automatic int unsigned wrap_add(input int unsigned a,
                                           input int unsigned b,
                                           input int unsigned n);
    return (a + b) % n;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// -----------------------------------------------------------------------------
// uart_tx_if -- connection between the arbiter and one UART transmitter.
//
// Signals:
//   uart_enable  arbiter -> UART  start request (UART i_enable)
//   uart_data    arbiter -> UART  word to send  (UART i_data)
//   uart_busy    UART -> arbiter  transmitter busy (UART o_busy)
//
// Modports: master (arbiter side), slave (UART side).
// -----------------------------------------------------------------------------
interface uart_tx_if
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) ();

  logic                  uart_enable;
  logic [DATA_WIDTH-1:0] uart_data;
  logic                  uart_busy;

  modport master (output uart_enable, output uart_data, input uart_busy);
  modport slave  (input uart_enable, input uart_data, output uart_busy);

endinterface

// File: rtl/rr_priority_select.sv
// -----------------------------------------------------------------------------
// rr_priority_select -- combinational round-robin pick.
//
// Returns the first set request bit at or after ptr, wrapping past the top.
//
// Ports:
//   req         request vector
//   ptr         index that has highest priority this cycle
//   valid       at least one request is set
//   sel_onehot  one-hot of the selected requester (zero when !valid)
//   sel_idx     index of the selected requester (zero when !valid)
// -----------------------------------------------------------------------------
module rr_priority_select
  import uart_pkg::*;
#(
  parameter int NUM_REQUESTERS = DEFAULT_NUM_REQUESTERS
) (
  input  logic [NUM_REQUESTERS-1:0]         req,
  input  logic [$clog2(NUM_REQUESTERS)-1:0] ptr,
  output logic                              valid,
  output logic [NUM_REQUESTERS-1:0]         sel_onehot,
  output logic [$clog2(NUM_REQUESTERS)-1:0] sel_idx
);

  localparam int IDX_W = $clog2(NUM_REQUESTERS);

  logic [IDX_W-1:0] cand;

  always_comb begin
    // NOTE: every variable written here gets a value before any branch, so no
    // path through the block can leave it holding its old value (no latch).
    valid      = 1'b0;
    sel_onehot = '0;
    sel_idx    = '0;
    cand       = '0;
    for (int i = 0; i < NUM_REQUESTERS; i++) begin
      cand = IDX_W'(wrap_add(32'(ptr), i, NUM_REQUESTERS));
      if (!valid && req[cand]) begin
        valid            = 1'b1;
        sel_onehot[cand] = 1'b1;
        sel_idx          = cand;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter -- shares one UART transmitter among NUM_REQUESTERS clients
// with round-robin priority.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-low reset
//   req        per-requester request, held until that requester's grant
//   req_data   requester i word in [i*INPUT_DATA_WIDTH +: INPUT_DATA_WIDTH]
//   grant      one-cycle one-hot pulse when a word is accepted
//   done       one-cycle one-hot pulse when that word has been sent
//   active_id  index of the current owner
//   arb_error  one-cycle pulse when the UART never went busy (timeout build)
//   uart       master side of uart_tx_if (uart_enable, uart_data, uart_busy)
//
// Optional feature macro: UART_ARB_TIMEOUT_EN. When defined, ISSUE gives up
// after BUSY_TIMEOUT cycles without uart_busy, pulses arb_error, moves the
// round-robin pointer on and passes through ERROR_RECOVER back to IDLE. When
// undefined, ISSUE waits for uart_busy indefinitely and arb_error is absent.
// -----------------------------------------------------------------------------
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQUESTERS   = DEFAULT_NUM_REQUESTERS,
  parameter int INPUT_DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int BUSY_TIMEOUT     = DEFAULT_BUSY_TIMEOUT
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic [NUM_REQUESTERS-1:0]                req,
  input  logic [NUM_REQUESTERS*INPUT_DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQUESTERS-1:0]                grant,
  output logic [NUM_REQUESTERS-1:0]                done,
  output logic [$clog2(NUM_REQUESTERS)-1:0]        active_id,
`ifdef UART_ARB_TIMEOUT_EN
  output logic                                     arb_error,
`endif
  uart_tx_if.master                                uart
);

  localparam int IDX_W = $clog2(NUM_REQUESTERS);
  localparam int W     = INPUT_DATA_WIDTH;

  arb_state_e                state_q, state_d;
  logic [IDX_W-1:0]          rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]          active_id_q, active_id_d;
  logic [NUM_REQUESTERS-1:0] grant_q, grant_d;
  logic [NUM_REQUESTERS-1:0] done_q, done_d;
  logic [W-1:0]              data_q, data_d;

  logic                      sel_valid;
  logic [NUM_REQUESTERS-1:0] sel_onehot;
  logic [IDX_W-1:0]          sel_idx;

`ifdef UART_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(BUSY_TIMEOUT + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             arb_error_q, arb_error_d;
`endif

  rr_priority_select #(
    .NUM_REQUESTERS (NUM_REQUESTERS)
  ) u_select (
    .req        (req),
    .ptr        (rr_ptr_q),
    .valid      (sel_valid),
    .sel_onehot (sel_onehot),
    .sel_idx    (sel_idx)
  );

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    active_id_d = active_id_q;
    grant_d     = '0;
    done_d      = '0;
    data_d      = data_q;
`ifdef UART_ARB_TIMEOUT_EN
    cnt_d       = '0;
    arb_error_d = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        // A UART still busy from an abandoned transfer blocks new grants.
        if (sel_valid && !uart.uart_busy) begin
          grant_d     = sel_onehot;
          active_id_d = sel_idx;
          for (int i = 0; i < NUM_REQUESTERS; i++) begin
            if (sel_onehot[i]) data_d = req_data[i*W +: W];
          end
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (uart.uart_busy) begin
          state_d = WAIT_DONE;
        end
`ifdef UART_ARB_TIMEOUT_EN
        else if (cnt_q == CNT_W'(BUSY_TIMEOUT - 1)) begin
          arb_error_d = 1'b1;
          rr_ptr_d    = IDX_W'(wrap_add(32'(active_id_q), 1, NUM_REQUESTERS));
          state_d     = ERROR_RECOVER;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      WAIT_DONE: begin
        if (!uart.uart_busy) begin
          done_d[active_id_q] = 1'b1;
          rr_ptr_d = IDX_W'(wrap_add(32'(active_id_q), 1, NUM_REQUESTERS));
          state_d  = IDLE;
        end
      end
`ifdef UART_ARB_TIMEOUT_EN
      ERROR_RECOVER: state_d = IDLE;
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (!reset) begin
      state_q     <= RESET_STATE;
      rr_ptr_q    <= '0;
      active_id_q <= '0;
      grant_q     <= '0;
      done_q      <= '0;
      data_q      <= '0;
`ifdef UART_ARB_TIMEOUT_EN
      cnt_q       <= CNT_W'(RESET_COUNT);
      arb_error_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      active_id_q <= active_id_d;
      grant_q     <= grant_d;
      done_q      <= done_d;
      data_q      <= data_d;
`ifdef UART_ARB_TIMEOUT_EN
      cnt_q       <= cnt_d;
      arb_error_q <= arb_error_d;
`endif
    end
  end

  // Enable drops combinationally the cycle busy is seen, so the UART never
  // observes enable together with its own busy flag.
  assign uart.uart_enable = (state_q == ISSUE) && !uart.uart_busy;
  assign uart.uart_data   = data_q;
  assign grant            = grant_q;
  assign done             = done_q;
  assign active_id        = active_id_q;
`ifdef UART_ARB_TIMEOUT_EN
  assign arb_error        = arb_error_q;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_arbiter -- self-checking bench for uart_tx_arbiter.
//
// A behavioural UART accepts a word when it samples enable while idle, stays
// busy for a random number of cycles and then delivers the word to rx_q.
// Expected owners come from the round-robin rule applied to the request mask;
// expected words come from the data each requester presented.
// With UART_ARB_TIMEOUT_EN defined the timeout path is exercised as well.
// -----------------------------------------------------------------------------
module tb_uart_tx_arbiter;

  localparam int N          = 4;
  localparam int W          = 8;
  localparam int TB_TIMEOUT = 16;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic [N-1:0]   req = '0;
  logic [N*W-1:0] req_data = '0;
  logic [N-1:0]   grant;
  logic [N-1:0]   done;
  logic [1:0]     active_id;
`ifdef UART_ARB_TIMEOUT_EN
  logic           arb_error;
`endif

  uart_tx_if #(.DATA_WIDTH(W)) uart_bus ();

  uart_tx_arbiter #(
    .NUM_REQUESTERS   (N),
    .INPUT_DATA_WIDTH (W),
    .BUSY_TIMEOUT     (TB_TIMEOUT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .req_data  (req_data),
    .grant     (grant),
    .done      (done),
    .active_id (active_id),
`ifdef UART_ARB_TIMEOUT_EN
    .arb_error (arb_error),
`endif
    .uart      (uart_bus)
  );

  always #5 clk = ~clk;

  int           checks = 0;
  int           errors = 0;
  int           model_ptr = 0;
  int           exp_owner = 0;
  logic [W-1:0] exp_data;
  logic [W-1:0] data_arr [N];
  logic [W-1:0] rx_q [$];
  bit           uart_stuck = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- behavioural UART transmitter ----------------
  int           busy_left = 0;
  logic [W-1:0] tx_word;
  always @(posedge clk) begin
    logic         en_s;
    logic [W-1:0] d_s;
    en_s = uart_bus.uart_enable;
    d_s  = uart_bus.uart_data;
    #1;
    if (busy_left > 0) begin
      busy_left--;
      if (busy_left == 0) begin
        uart_bus.uart_busy = 1'b0;
        rx_q.push_back(tx_word);
      end
    end else if (en_s === 1'b1 && !uart_stuck) begin
      tx_word            = d_s;
      busy_left          = $urandom_range(6, 2);
      uart_bus.uart_busy = 1'b1;
    end
  end

  // ---------------- per-cycle invariants ----------------
  bit           in_tx = 1'b0;
  logic [W-1:0] held;
  always @(negedge clk) begin
    check("enable_with_busy", 32'(uart_bus.uart_enable & uart_bus.uart_busy), 32'd0);
    check("grant_onehot0", 32'($onehot0(grant)), 32'd1);
    check("done_onehot0", 32'($onehot0(done)), 32'd1);
    if (!reset) begin
      in_tx = 1'b0;
    end else begin
      if (|grant) begin
        in_tx = 1'b1;
        held  = uart_bus.uart_data;
      end else if (in_tx) begin
        check("data_stable", 32'(uart_bus.uart_data), 32'(held));
      end
      if (|done) in_tx = 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
      if (arb_error) in_tx = 1'b0;
`endif
    end
  end

  // ---------------- reference model and helpers ----------------
  function automatic int model_pick(input logic [N-1:0] m, input int ptr);
    for (int k = 0; k < N; k++) begin
      int c;
      c = (ptr + k) % N;
      if (m[c] === 1'b1) return c;
    end
    return 0;
  endfunction

  task automatic raise(input int i, input logic [W-1:0] d);
    data_arr[i]          = d;
    req_data[i*W +: W]   = d;
    req[i]               = 1'b1;
  endtask

  task automatic wait_grant(output int idx, output int lat);
    idx = -1;
    lat = -1;
    for (int c = 1; c <= 64; c++) begin
      @(negedge clk);
      if (|grant) begin
        for (int i = 0; i < N; i++) if (grant[i]) idx = i;
        lat = c;
        return;
      end
    end
  endtask

  task automatic wait_done(output int idx);
    idx = -1;
    for (int c = 1; c <= 64; c++) begin
      @(negedge clk);
      if (|done) begin
        for (int i = 0; i < N; i++) if (done[i]) idx = i;
        return;
      end
    end
  endtask

  task automatic grant_phase(input string tag, input int exp_idx, input int exp_lat);
    int g, lat;
    exp_data  = data_arr[exp_idx];
    exp_owner = exp_idx;
    wait_grant(g, lat);
    check({tag, "_grant_idx"}, 32'(g), 32'(exp_idx));
    check({tag, "_grant_latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "_active_id"}, 32'(active_id), 32'(exp_idx));
    check({tag, "_uart_data"}, 32'(uart_bus.uart_data), 32'(exp_data));
    check({tag, "_enable_at_grant"}, 32'(uart_bus.uart_enable), 32'd1);
    if (g >= 0) req[g] = 1'b0;
  endtask

  task automatic done_phase(input string tag);
    int d;
    wait_done(d);
    check({tag, "_done_idx"}, 32'(d), 32'(exp_owner));
    model_ptr = (exp_owner + 1) % N;
    check({tag, "_rx_count"}, 32'(rx_q.size()), 32'd1);
    if (rx_q.size() > 0) check({tag, "_rx_word"}, 32'(rx_q.pop_front()), 32'(exp_data));
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    model_ptr = 0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- directed and random sequence ----------------
  initial begin
    int  g, lat;
    bit  saw_done;
    uart_bus.uart_busy = 1'b0;
    for (int i = 0; i < N; i++) data_arr[i] = '0;

    // Reset state.
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_enable", 32'(uart_bus.uart_enable), 32'd0);
    check("rst_data", 32'(uart_bus.uart_data), 32'd0);
    check("rst_active_id", 32'(active_id), 32'd0);
`ifdef UART_ARB_TIMEOUT_EN
    check("rst_arb_error", 32'(arb_error), 32'd0);
`endif
    reset = 1'b1;
    @(negedge clk);

    // Single requester, known word.
    raise(0, 8'hA5);
    grant_phase("single", 0, 1);
    done_phase("single");

    // All four requesting from pointer 0: order 0,1,2,3 then 0 again.
    pulse_reset();
    raise(0, 8'h11); raise(1, 8'h22); raise(2, 8'h33); raise(3, 8'h44);
    for (int k = 0; k < N; k++) begin
      grant_phase("all4", k, 1);
      if (k == N - 1) raise(0, 8'h55);
      done_phase("all4");
    end
    grant_phase("all4_wrap", 0, 1);
    done_phase("all4_wrap");

    // Move pointer to 2, then requester 2 continuous with 1 arriving: 2,1,2.
    raise(1, W'($urandom));
    grant_phase("to_ptr2", 1, 1);
    done_phase("to_ptr2");
    raise(2, W'($urandom)); raise(1, W'($urandom));
    grant_phase("alt_a", 2, 1);
    raise(2, W'($urandom));
    done_phase("alt_a");
    grant_phase("alt_b", 1, 1);
    done_phase("alt_b");
    grant_phase("alt_c", 2, 1);
    done_phase("alt_c");

    // Random masks, random withdrawals before grant, changes after grant.
    for (int it = 0; it < 24; it++) begin
      if (req == '0) begin
        for (int i = 0; i < N; i++) if ($urandom_range(1, 0) == 1) raise(i, W'($urandom));
        if (req == '0) raise(int'($urandom_range(N - 1, 0)), W'($urandom));
      end
      grant_phase("rand", model_pick(req, model_ptr), 1);
      for (int i = 0; i < N; i++) begin
        if (req[i] && $urandom_range(3, 0) == 0) req[i] = 1'b0;
        else if (!req[i] && $urandom_range(1, 0) == 1) raise(i, W'($urandom));
      end
      done_phase("rand");
    end
    req = '0;
    @(negedge clk);

    // Reset in WAIT_DONE of requester 1: transfer abandoned, no done pulse.
    raise(1, W'($urandom));
    grant_phase("abort", 1, 1);
    for (int c = 0; c < 32 && uart_bus.uart_busy !== 1'b1; c++) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("abort_enable", 32'(uart_bus.uart_enable), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    saw_done = 1'b0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (done[1] === 1'b1) saw_done = 1'b1;
    end
    check("abort_no_done1", 32'(saw_done), 32'd0);
    rx_q.delete();
    model_ptr = 0;
    raise(1, W'($urandom));
    grant_phase("after_abort", 1, 1);
    done_phase("after_abort");

`ifdef UART_ARB_TIMEOUT_EN
    // UART never goes busy: arb_error after TB_TIMEOUT cycles of ISSUE.
    begin
      bit early_err, en_held;
      early_err  = 1'b0;
      en_held    = 1'b1;
      uart_stuck = 1'b1;
      raise(2, W'($urandom));
      grant_phase("tmo", 2, 1);
      for (int c = 1; c < TB_TIMEOUT; c++) begin
        @(negedge clk);
        if (arb_error !== 1'b0) early_err = 1'b1;
        if (uart_bus.uart_enable !== 1'b1) en_held = 1'b0;
      end
      check("tmo_no_early_error", 32'(early_err), 32'd0);
      check("tmo_enable_held", 32'(en_held), 32'd1);
      @(negedge clk);
      check("tmo_arb_error", 32'(arb_error), 32'd1);
      check("tmo_enable_dropped", 32'(uart_bus.uart_enable), 32'd0);
      check("tmo_no_done", 32'(done), 32'd0);
      uart_stuck = 1'b0;
      model_ptr  = 3;
      raise(0, W'($urandom)); raise(3, W'($urandom));
      grant_phase("tmo_next", 3, 2);
      done_phase("tmo_next");
      grant_phase("tmo_next2", 0, 1);
      done_phase("tmo_next2");
    end
`endif

    repeat (4) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
